// File: rtl/filter_ram_pkg.sv
// Shared definitions for the filter RAM write and read sides.
//   - FILTER_DATA_W / FILTER_ADDR_W : default weight width and RAM address
//     width, common to the loader and the read-side address counter.
//   - filter_state_e : loader states (IDLE, LOAD, COMMIT, READY).
package filter_ram_pkg;

  localparam int FILTER_DATA_W = 8;
  localparam int FILTER_ADDR_W = 5;

  typedef enum logic [1:0] {
    FS_IDLE   = 2'd0,
    FS_LOAD   = 2'd1,
    FS_COMMIT = 2'd2,
    FS_READY  = 2'd3
  } filter_state_e;

endpackage

// File: rtl/filter_wr_addr_cnt.sv
// Write-address counter for the filter RAM loader.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear to 0 (takes priority over en)
//   en       : advance by one; ignored once the terminal count is reached
//   count    : current write address
//   tc       : count == NUM_WORDS-1
// The counter saturates at NUM_WORDS-1 instead of wrapping, so a full
// 2^ADDR_W filter ends on the all-ones address.
module filter_wr_addr_cnt #(
  parameter int ADDR_W    = 5,
  parameter int NUM_WORDS = 25
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  output logic [ADDR_W-1:0] count,
  output logic              tc
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_WORDS - 1);

  assign tc = (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/filter_ram_loader.sv
// Filter RAM write-side controller. Accepts NUM_WORDS weights over a
// valid/ready stream, writes them to RAM addresses 0..NUM_WORDS-1 through a
// registered write port, then raises FILTER_VALID until the read side
// answers with RELEASE.
//   CLK, RST      : clock, asynchronous active-high reset
//   START         : one-cycle request to load a filter (IDLE, or READY with RELEASE)
//   IN_VALID/IN_DATA/IN_READY : weight input stream
//   RAM_WE/RAM_WADDR/RAM_WDATA : filter RAM write port (one-cycle latency)
//   FILTER_VALID  : complete filter resident in RAM
//   RELEASE       : read side done with the current filter
//   BUSY          : loading or committing
module filter_ram_loader
  import filter_ram_pkg::*;
#(
  parameter int DATA_W    = FILTER_DATA_W,
  parameter int ADDR_W    = FILTER_ADDR_W,
  parameter int NUM_WORDS = 25
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              IN_VALID,
  input  logic [DATA_W-1:0] IN_DATA,
  output logic              IN_READY,
  output logic              RAM_WE,
  output logic [ADDR_W-1:0] RAM_WADDR,
  output logic [DATA_W-1:0] RAM_WDATA,
  output logic              FILTER_VALID,
  input  logic              RELEASE,
  output logic              BUSY
);

  localparam logic [1:0] ST_IDLE   = FS_IDLE;
  localparam logic [1:0] ST_LOAD   = FS_LOAD;
  localparam logic [1:0] ST_COMMIT = FS_COMMIT;
  localparam logic [1:0] ST_READY  = FS_READY;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [ADDR_W-1:0] wr_count;
  logic              wr_tc;
  logic              beat;
  logic              load_entry;

  // Outputs decode only the registered state: no input-to-output path.
  assign IN_READY     = (state == ST_LOAD);
  assign FILTER_VALID = (state == ST_READY);
  assign BUSY         = (state == ST_LOAD) || (state == ST_COMMIT);

  assign beat = IN_READY && IN_VALID;

  // A reload (START together with RELEASE in READY) restarts at address 0
  // exactly like a fresh START from IDLE.
  assign load_entry = ((state == ST_IDLE) && START) ||
                      ((state == ST_READY) && START && RELEASE);

  filter_wr_addr_cnt #(
    .ADDR_W    (ADDR_W),
    .NUM_WORDS (NUM_WORDS)
  ) u_addr_cnt (
    .clk   (CLK),
    .rst   (RST),
    .clr   (load_entry),
    .en    (beat),
    .count (wr_count),
    .tc    (wr_tc)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (START) state_nxt = ST_LOAD;
      ST_LOAD:   if (beat && wr_tc) state_nxt = ST_COMMIT;
      // The last word is on the write port during COMMIT, so READY follows
      // only once the RAM holds every word.
      ST_COMMIT: state_nxt = ST_READY;
      ST_READY:  if (RELEASE) state_nxt = START ? ST_LOAD : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      RAM_WE    <= 1'b0;
      RAM_WADDR <= '0;
      RAM_WDATA <= '0;
    end else begin
      state  <= state_nxt;
      RAM_WE <= beat;
      // Address/data hold their last value between writes.
      if (beat) begin
        RAM_WADDR <= wr_count;
        RAM_WDATA <= IN_DATA;
      end
    end
  end

endmodule

// File: tb/tb_filter_ram_loader.sv
module tb_filter_ram_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       rel = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic       rdy0, we0, fv0, busy0;
  logic [4:0] waddr0;
  logic [7:0] wdata0;
  logic       rdy1, we1, fv1, busy1;
  logic [4:0] waddr1;
  logic [7:0] wdata1;

  int n_tests = 0;
  int n_fail  = 0;
  int wc0 = 0;
  int wc1 = 0;
  int last_addr1 = 0;

  // Reference model: words accepted so far, and which phase of a filter
  // load each instance is in, derived from the handshake rules.
  int nw[2] = '{25, 32};
  bit m_load[2];
  bit m_commit[2];
  bit m_ready[2];
  bit m_we[2];
  int m_cnt[2];
  int m_addr[2];
  int m_data[2];

  always #5 clk = ~clk;

  filter_ram_loader #(.DATA_W(8), .ADDR_W(5), .NUM_WORDS(25)) dut25 (
    .CLK(clk), .RST(rst), .START(start), .IN_VALID(in_valid),
    .IN_DATA(in_data), .IN_READY(rdy0), .RAM_WE(we0), .RAM_WADDR(waddr0),
    .RAM_WDATA(wdata0), .FILTER_VALID(fv0), .RELEASE(rel), .BUSY(busy0)
  );

  filter_ram_loader #(.DATA_W(8), .ADDR_W(5), .NUM_WORDS(32)) dut32 (
    .CLK(clk), .RST(rst), .START(start), .IN_VALID(in_valid),
    .IN_DATA(in_data), .IN_READY(rdy1), .RAM_WE(we1), .RAM_WADDR(waddr1),
    .RAM_WDATA(wdata1), .FILTER_VALID(fv1), .RELEASE(rel), .BUSY(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_load[i] = 0; m_commit[i] = 0; m_ready[i] = 0; m_we[i] = 0;
      m_cnt[i] = 0; m_addr[i] = 0; m_data[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      bit accept;
      accept = m_load[i] && in_valid;
      m_we[i] = accept;
      if (accept) begin
        m_addr[i] = m_cnt[i];
        m_data[i] = int'(in_data);
      end
      if (m_load[i]) begin
        if (accept) begin
          if (m_cnt[i] == nw[i] - 1) begin
            m_load[i] = 0;
            m_commit[i] = 1;
          end else begin
            m_cnt[i]++;
          end
        end
      end else if (m_commit[i]) begin
        m_commit[i] = 0;
        m_ready[i] = 1;
      end else if (m_ready[i]) begin
        if (rel) begin
          m_ready[i] = 0;
          if (start) begin
            m_load[i] = 1;
            m_cnt[i] = 0;
          end
        end
      end else if (start) begin
        m_load[i] = 1;
        m_cnt[i] = 0;
      end
    end
  endtask

  task automatic check_one(input int i, input logic r, input logic w,
                           input logic [4:0] a, input logic [7:0] d,
                           input logic f, input logic b);
    chk($sformatf("n%0d_in_ready", nw[i]), 32'(r), 32'(m_load[i]));
    chk($sformatf("n%0d_ram_we", nw[i]), 32'(w), 32'(m_we[i]));
    chk($sformatf("n%0d_ram_waddr", nw[i]), 32'(a), 32'(m_addr[i]));
    chk($sformatf("n%0d_ram_wdata", nw[i]), 32'(d), 32'(m_data[i]));
    chk($sformatf("n%0d_filter_valid", nw[i]), 32'(f), 32'(m_ready[i]));
    chk($sformatf("n%0d_busy", nw[i]), 32'(b), 32'(m_load[i] || m_commit[i]));
  endtask

  task automatic check_all();
    check_one(0, rdy0, we0, waddr0, wdata0, fv0, busy0);
    check_one(1, rdy1, we1, waddr1, wdata1, fv1, busy1);
  endtask

  task automatic cyc(input logic s, input logic v, input logic [7:0] d, input logic r);
    start = s; in_valid = v; in_data = d; rel = r;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    if (we0) wc0++;
    if (we1) begin
      wc1++;
      last_addr1 = int'(waddr1);
    end
  endtask

  initial begin
    model_reset();
    // Power-on reset, checked before any clock edge.
    #1 rst = 1'b1;
    #1 check_all();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Idle with IN_VALID high and stray RELEASE: nothing may happen.
    for (int k = 0; k < 20; k++) cyc(1'b0, 1'b1, 8'($urandom), 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 8'h00, 1'b1);

    // Full load with continuous valid; START at word 7 must be ignored.
    wc0 = 0; wc1 = 0;
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 34; k++) cyc(k == 7, 1'b1, 8'(8'h10 + k), 1'b0);
    chk("n25_write_count", 32'(wc0), 32'd25);
    chk("n32_write_count", 32'(wc1), 32'd32);
    chk("n32_last_addr", 32'(last_addr1), 32'd31);

    // READY holds without RELEASE, then RELEASE returns to IDLE.
    for (int k = 0; k < 10; k++) cyc(1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);

    // Bubbled load: IN_VALID alternates.
    wc0 = 0; wc1 = 0;
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 70; k++) cyc(1'b0, (k % 2) == 0, 8'($urandom), 1'b0);
    chk("n25_bubble_writes", 32'(wc0), 32'd25);
    chk("n32_bubble_writes", 32'(wc1), 32'd32);

    // START and RELEASE together in READY reload from address 0,
    // then an asynchronous reset at word 12.
    cyc(1'b1, 1'b0, 8'h00, 1'b1);
    for (int k = 0; k < 12; k++) cyc(1'b0, 1'b1, 8'($urandom), 1'b0);
    chk("n25_we_before_reset", 32'(we0), 32'd1);
    #2 rst = 1'b1;
    model_reset();
    #1 check_all();
    #1 rst = 1'b0;

    // Reload after reset starts at address 0 again.
    wc0 = 0; wc1 = 0;
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 36; k++) cyc(1'b0, 1'b1, 8'($urandom), 1'b0);
    chk("n25_reload_writes", 32'(wc0), 32'd25);
    chk("n32_reload_writes", 32'(wc1), 32'd32);

    // Randomised control and data traffic.
    for (int k = 0; k < 500; k++)
      cyc($urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
          8'($urandom), $urandom_range(0, 3) == 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
